// File: rtl/hazard_pkg.sv
// Shared types and constants for the D->EX hazard and flush controller.
// The optional counters are enabled with HAZARD_PERF_CNT_EN.
package hazard_pkg;

  // Width of the multiply down-counter; holds MUL_LAT-2 for MUL_LAT up to 16.
  localparam int MUL_CNT_W    = 4;
  // Default width of PCs and the redirect target.
  localparam int VPC_BITS_DEF = 32;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    MUL_WAIT = 1'b1
  } state_e;

endpackage

// File: rtl/ex_hazard_ctrl_mul_seq.sv
// Multiply sequencer. It holds a multiply in EX for MUL_LAT cycles in total,
// which is MUL_LAT-1 hold cycles. The counter runs freely and ignores memory
// stalls. mul_busy reflects the FSM state directly (1 = MUL_WAIT).
module mul_seq
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic EX_mul,
  output logic ex_hold,
  output logic mul_busy
);

  localparam logic [MUL_CNT_W-1:0] CNT_LOAD =
    (MUL_LAT > 1) ? MUL_CNT_W'(MUL_LAT - 2) : '0;

  state_e               state_q, state_d;
  logic [MUL_CNT_W-1:0] cnt_q, cnt_d;

  // Next state and hold: IDLE starts the hold, MUL_WAIT counts the rest down.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ex_hold = 1'b0;
    case (state_q)
      IDLE: begin
        if (EX_mul && (MUL_LAT > 1)) begin
          ex_hold = 1'b1;
          state_d = MUL_WAIT;
          cnt_d   = CNT_LOAD;
        end
      end
      MUL_WAIT: begin
        ex_hold = (cnt_q != '0);
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and counter registers; reset returns to IDLE even mid-multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign mul_busy = (state_q == MUL_WAIT);

endmodule

// File: rtl/ex_hazard_ctrl.sv
// Hazard and flush controller for the D->EX boundary: load-use bubbles,
// multiply holds and branch-mispredict redirects. Defining HAZARD_PERF_CNT_EN
// adds three wrapping event counters.
module ex_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int VPC_BITS = VPC_BITS_DEF,
  parameter int MUL_LAT  = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                D_valid,
  input  logic [4:0]          D_rs1,
  input  logic [4:0]          D_rs2,
  input  logic                D_use_rs1,
  input  logic                D_use_rs2,
  input  logic [4:0]          EX_rd,
  input  logic                EX_ld,
  input  logic                EX_we,
  input  logic                EX_mul,
  input  logic                EX_brn,
  input  logic                EX_BP_taken,
  input  logic [VPC_BITS-1:0] EX_BP_target_pc,
  input  logic                EX_br_taken,
  input  logic [VPC_BITS-1:0] EX_br_target,
  input  logic [VPC_BITS-1:0] EX_pc_plus4,
  input  logic                MEM_stall,
  output logic                stall_D,
  output logic                stall_F,
  output logic                ex_hold,
  output logic                EX_taken,
  output logic                redirect_valid,
  output logic [VPC_BITS-1:0] redirect_pc,
  output logic                mul_busy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]         cnt_lu_stall,
  output logic [31:0]         cnt_mul_hold,
  output logic [31:0]         cnt_mispredict
`endif
);

  logic lu;
  logic mp;
  logic ex_free;

  mul_seq #(
    .MUL_LAT (MUL_LAT)
  ) u_mul_seq (
    .clk      (clk),
    .rst      (rst),
    .EX_mul   (EX_mul),
    .ex_hold  (ex_hold),
    .mul_busy (mul_busy)
  );

  // Hazard detection, priority gating and the redirect mux. A held EX (memory
  // stall or multiply) is never bubbled or flushed; a flush outranks load-use
  // because it already discards D.
  always_comb begin
    lu = EX_ld && EX_we && (EX_rd != 5'd0) && D_valid &&
         ((D_use_rs1 && (D_rs1 == EX_rd)) || (D_use_rs2 && (D_rs2 == EX_rd)));
    mp = EX_brn && ((EX_br_taken != EX_BP_taken) ||
                    (EX_br_taken && EX_BP_taken && (EX_br_target != EX_BP_target_pc)));
    ex_free        = !MEM_stall && !ex_hold;
    EX_taken       = ex_free && mp;
    redirect_valid = EX_taken;
    stall_D        = ex_free && !mp && lu;
    stall_F        = MEM_stall || ex_hold || stall_D;
    redirect_pc    = '0;
    if (redirect_valid) begin
      redirect_pc = EX_br_taken ? EX_br_target : EX_pc_plus4;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] cnt_lu_q, cnt_lu_d;
  logic [31:0] cnt_mul_q, cnt_mul_d;
  logic [31:0] cnt_mp_q, cnt_mp_d;

  // Count cycles in which each control is actually asserted.
  always_comb begin
    cnt_lu_d  = cnt_lu_q  + 32'(stall_D);
    cnt_mul_d = cnt_mul_q + 32'(ex_hold);
    cnt_mp_d  = cnt_mp_q  + 32'(EX_taken);
  end

  // Counter registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_lu_q  <= '0;
      cnt_mul_q <= '0;
      cnt_mp_q  <= '0;
    end else begin
      cnt_lu_q  <= cnt_lu_d;
      cnt_mul_q <= cnt_mul_d;
      cnt_mp_q  <= cnt_mp_d;
    end
  end

  assign cnt_lu_stall   = cnt_lu_q;
  assign cnt_mul_hold   = cnt_mul_q;
  assign cnt_mispredict = cnt_mp_q;
`endif

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed testbench for ex_hazard_ctrl (MUL_LAT=3 main instance plus a
// MUL_LAT=1 instance). Output bundle order: {stall_D, stall_F, ex_hold,
// EX_taken, redirect_valid, mul_busy}.
module tb_ex_hazard_ctrl;

  localparam int VPC_BITS = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                D_valid;
  logic [4:0]          D_rs1, D_rs2;
  logic                D_use_rs1, D_use_rs2;
  logic [4:0]          EX_rd;
  logic                EX_ld, EX_we, EX_mul, EX_brn;
  logic                EX_BP_taken;
  logic [VPC_BITS-1:0] EX_BP_target_pc;
  logic                EX_br_taken;
  logic [VPC_BITS-1:0] EX_br_target;
  logic [VPC_BITS-1:0] EX_pc_plus4;
  logic                MEM_stall;

  logic                stall_D, stall_F, ex_hold, EX_taken, redirect_valid, mul_busy;
  logic [VPC_BITS-1:0] redirect_pc;
  logic                stall_D1, stall_F1, ex_hold1, EX_taken1, redirect_valid1, mul_busy1;
  logic [VPC_BITS-1:0] redirect_pc1;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0]         cnt_lu_stall, cnt_mul_hold, cnt_mispredict;
  logic [31:0]         cnt_lu_stall1, cnt_mul_hold1, cnt_mispredict1;
`endif

  int checks   = 0;
  int failures = 0;

  logic [5:0] outs;
  assign outs = {stall_D, stall_F, ex_hold, EX_taken, redirect_valid, mul_busy};

  // Clock / reset
  always #5 clk = ~clk;

  ex_hazard_ctrl #(.VPC_BITS(VPC_BITS), .MUL_LAT(3)) dut (
    .clk(clk), .rst(rst), .D_valid(D_valid), .D_rs1(D_rs1), .D_rs2(D_rs2),
    .D_use_rs1(D_use_rs1), .D_use_rs2(D_use_rs2), .EX_rd(EX_rd), .EX_ld(EX_ld),
    .EX_we(EX_we), .EX_mul(EX_mul), .EX_brn(EX_brn), .EX_BP_taken(EX_BP_taken),
    .EX_BP_target_pc(EX_BP_target_pc), .EX_br_taken(EX_br_taken),
    .EX_br_target(EX_br_target), .EX_pc_plus4(EX_pc_plus4), .MEM_stall(MEM_stall),
    .stall_D(stall_D), .stall_F(stall_F), .ex_hold(ex_hold), .EX_taken(EX_taken),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .mul_busy(mul_busy)
`ifdef HAZARD_PERF_CNT_EN
    , .cnt_lu_stall(cnt_lu_stall), .cnt_mul_hold(cnt_mul_hold), .cnt_mispredict(cnt_mispredict)
`endif
  );

  ex_hazard_ctrl #(.VPC_BITS(VPC_BITS), .MUL_LAT(1)) dut_lat1 (
    .clk(clk), .rst(rst), .D_valid(D_valid), .D_rs1(D_rs1), .D_rs2(D_rs2),
    .D_use_rs1(D_use_rs1), .D_use_rs2(D_use_rs2), .EX_rd(EX_rd), .EX_ld(EX_ld),
    .EX_we(EX_we), .EX_mul(EX_mul), .EX_brn(EX_brn), .EX_BP_taken(EX_BP_taken),
    .EX_BP_target_pc(EX_BP_target_pc), .EX_br_taken(EX_br_taken),
    .EX_br_target(EX_br_target), .EX_pc_plus4(EX_pc_plus4), .MEM_stall(MEM_stall),
    .stall_D(stall_D1), .stall_F(stall_F1), .ex_hold(ex_hold1), .EX_taken(EX_taken1),
    .redirect_valid(redirect_valid1), .redirect_pc(redirect_pc1), .mul_busy(mul_busy1)
`ifdef HAZARD_PERF_CNT_EN
    , .cnt_lu_stall(cnt_lu_stall1), .cnt_mul_hold(cnt_mul_hold1), .cnt_mispredict(cnt_mispredict1)
`endif
  );

  // Driver tasks
  task automatic idle_in();
    D_valid = 1'b0; D_rs1 = '0; D_rs2 = '0; D_use_rs1 = 1'b0; D_use_rs2 = 1'b0;
    EX_rd = '0; EX_ld = 1'b0; EX_we = 1'b0; EX_mul = 1'b0; EX_brn = 1'b0;
    EX_BP_taken = 1'b0; EX_BP_target_pc = '0; EX_br_taken = 1'b0;
    EX_br_target = '0; EX_pc_plus4 = '0; MEM_stall = 1'b0;
  endtask

  // Advance to just after the next active edge, where inputs are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wait to mid-cycle, where outputs are sampled.
  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2);
    EX_ld = 1'b1; EX_we = 1'b1; EX_rd = rd; D_valid = 1'b1;
    D_rs1 = rs1; D_use_rs1 = u1; D_rs2 = rs2; D_use_rs2 = u2;
  endtask

  task automatic set_br(input logic bp, input logic bt, input logic [31:0] bp_tgt,
                        input logic [31:0] tgt, input logic [31:0] pc4);
    EX_brn = 1'b1; EX_BP_taken = bp; EX_br_taken = bt;
    EX_BP_target_pc = bp_tgt; EX_br_target = tgt; EX_pc_plus4 = pc4;
  endtask

  // Scoreboard comparison
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [5:0] exp_o, input logic [31:0] exp_pc);
    chk({tag, "_outs"}, 32'(outs), 32'(exp_o));
    chk({tag, "_pc"}, redirect_pc, exp_pc);
  endtask

  initial begin
    rst = 1'b1;
    idle_in();
    tick(); tick();
    sample(); chk_all("in_reset", 6'b000000, 32'h0);
    tick(); rst = 1'b0;
    sample(); chk_all("after_reset", 6'b000000, 32'h0);

    // Load-use on rs2 = x5: one cycle of stall, bubble clears it.
    tick(); set_lu(5'd5, 5'd3, 1'b1, 5'd5, 1'b1);
    sample(); chk_all("lu_rs2", 6'b110000, 32'h0);
    tick(); idle_in(); D_valid = 1'b1; D_rs2 = 5'd5; D_use_rs2 = 1'b1;
    sample(); chk_all("lu_bubble", 6'b000000, 32'h0);
    tick(); set_lu(5'd7, 5'd7, 1'b1, 5'd1, 1'b0);
    sample(); chk_all("lu_rs1", 6'b110000, 32'h0);
    tick(); idle_in(); set_lu(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    sample(); chk_all("lu_x0", 6'b000000, 32'h0);
    tick(); idle_in(); set_lu(5'd9, 5'd9, 1'b0, 5'd2, 1'b1);
    sample(); chk_all("lu_unused_rs", 6'b000000, 32'h0);
    tick(); idle_in(); set_lu(5'd9, 5'd9, 1'b1, 5'd2, 1'b1); D_valid = 1'b0;
    sample(); chk_all("lu_d_invalid", 6'b000000, 32'h0);
    tick(); idle_in(); set_lu(5'd9, 5'd9, 1'b1, 5'd2, 1'b1); EX_ld = 1'b0;
    sample(); chk_all("lu_not_load", 6'b000000, 32'h0);

    // Multiply, MUL_LAT=3: two hold cycles, busy in the second, then idle.
    tick(); idle_in(); EX_mul = 1'b1;
    sample(); chk_all("mul_c0", 6'b011000, 32'h0);
    chk("lat1_c0", 32'({ex_hold1, mul_busy1, stall_F1}), 32'h0);
    tick();
    sample(); chk_all("mul_c1", 6'b011001, 32'h0);
    chk("lat1_c1", 32'({ex_hold1, mul_busy1, stall_F1}), 32'h0);
    tick();
    sample(); chk_all("mul_c2", 6'b000001, 32'h0);
    tick(); EX_mul = 1'b0;
    sample(); chk_all("mul_done", 6'b000000, 32'h0);

    // Multiply with MEM_stall during the hold: counter keeps running.
    tick(); EX_mul = 1'b1; MEM_stall = 1'b1;
    sample(); chk_all("mulms_c0", 6'b011000, 32'h0);
    tick();
    sample(); chk_all("mulms_c1", 6'b011001, 32'h0);
    tick();
    sample(); chk_all("mulms_c2", 6'b010001, 32'h0);
    tick(); idle_in();
    sample(); chk_all("mulms_done", 6'b000000, 32'h0);

    // Mispredicts.
    tick(); set_br(1'b0, 1'b1, 32'h200, 32'h100, 32'h44);
    sample(); chk_all("mp_nt_t", 6'b000110, 32'h100);
    tick(); idle_in();
    sample(); chk_all("mp_gone", 6'b000000, 32'h0);
    tick(); set_br(1'b1, 1'b0, 32'h200, 32'h100, 32'h44);
    sample(); chk_all("mp_t_nt", 6'b000110, 32'h44);
    tick(); idle_in(); set_br(1'b1, 1'b1, 32'h300, 32'h300, 32'h44);
    sample(); chk_all("br_correct", 6'b000000, 32'h0);
    tick(); idle_in(); set_br(1'b1, 1'b1, 32'h300, 32'h380, 32'h44);
    sample(); chk_all("mp_tgt", 6'b000110, 32'h380);
    tick(); idle_in(); set_br(1'b0, 1'b0, 32'h300, 32'h380, 32'h44);
    sample(); chk_all("br_nt_ok", 6'b000000, 32'h0);

    // Mispredict together with a load-use match: flush wins, no stall.
    tick(); idle_in(); set_br(1'b0, 1'b1, 32'h0, 32'h100, 32'h44);
    set_lu(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    sample(); chk_all("mp_lu", 6'b000110, 32'h100);
    // Same with MEM_stall for two cycles: flush only in the third.
    tick(); MEM_stall = 1'b1;
    sample(); chk_all("mp_lu_ms1", 6'b010000, 32'h0);
    tick();
    sample(); chk_all("mp_lu_ms2", 6'b010000, 32'h0);
    tick(); MEM_stall = 1'b0;
    sample(); chk_all("mp_lu_ms3", 6'b000110, 32'h100);

    // Reset during MUL_WAIT.
    tick(); idle_in(); EX_mul = 1'b1;
    sample(); chk_all("mulrst_c0", 6'b011000, 32'h0);
    tick(); rst = 1'b1;
    sample(); chk_all("mulrst_c1", 6'b011001, 32'h0);
    tick(); rst = 1'b0; idle_in();
    sample(); chk_all("mulrst_after", 6'b000000, 32'h0);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_rst_lu", cnt_lu_stall, 32'd0);
    chk("perf_rst_mul", cnt_mul_hold, 32'd0);
    chk("perf_rst_mp", cnt_mispredict, 32'd0);
`endif

    // Event mix: two load-use stalls, one multiply, one mispredict.
    tick(); set_lu(5'd4, 5'd4, 1'b1, 5'd0, 1'b0);
    sample(); chk_all("mix_lu1", 6'b110000, 32'h0);
    tick(); idle_in();
    tick(); set_lu(5'd6, 5'd0, 1'b0, 5'd6, 1'b1);
    sample(); chk_all("mix_lu2", 6'b110000, 32'h0);
    tick(); idle_in(); EX_mul = 1'b1;
    tick();
    tick();
    tick(); EX_mul = 1'b0; set_br(1'b1, 1'b0, 32'h500, 32'h500, 32'h88);
    sample(); chk_all("mix_mp", 6'b000110, 32'h88);
    tick(); idle_in();
    sample(); chk_all("mix_end", 6'b000000, 32'h0);
`ifdef HAZARD_PERF_CNT_EN
    chk("perf_lu", cnt_lu_stall, 32'd2);
    chk("perf_mul", cnt_mul_hold, 32'd2);
    chk("perf_mp", cnt_mispredict, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ex_hazard_ctrl.md
Name: ex_hazard_ctrl

Overview:
Pipeline hazard and flush controller for the D->EX boundary. It watches the EX-stage control outputs of the decode/execute pipeline register together with the operand usage of the instruction currently in D. From these it generates the bubble, hold and flush controls the decode/execute register consumes: stall_D, EX_taken, and an EX hold term that the top level ORs into MEM_stall. It also sequences multi-cycle multiplies and drives the fetch redirect on branch mispredict.

Parameters:
VPC_BITS, 32, width of PCs and redirect target
MUL_LAT, 3, cycles a multiply occupies EX (legal 1..16)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
D_valid  in  1  D holds a real instruction
D_rs1  in  5  D source register 1
D_rs2  in  5  D source register 2
D_use_rs1  in  1  D reads rs1
D_use_rs2  in  1  D reads rs2
EX_rd  in  5  EX destination register
EX_ld  in  1  EX is a load
EX_we  in  1  EX writes a register
EX_mul  in  1  EX is a multiply
EX_brn  in  1  EX is a branch
EX_BP_taken  in  1  prediction made at fetch
EX_BP_target_pc  in  VPC_BITS  predicted target
EX_br_taken  in  1  resolved branch outcome
EX_br_target  in  VPC_BITS  resolved taken target
EX_pc_plus4  in  VPC_BITS  fall-through PC
MEM_stall  in  1  external memory stall
stall_D  out  1  insert bubble into EX
stall_F  out  1  hold PC and F/D register
ex_hold  out  1  hold EX (top ORs into MEM_stall)
EX_taken  out  1  flush D/EX, one cycle
redirect_valid  out  1  load redirect_pc into PC
redirect_pc  out  VPC_BITS  corrected fetch PC
mul_busy  out  1  multiply sequencing active

Behaviour:
- Reset: state IDLE, counter 0. All outputs 0 while rst=1 and in the first cycle after reset, provided the inputs are idle.
- FSM states: IDLE, MUL_WAIT. 4-bit down-counter cnt.
- Multiply:
  - In IDLE with EX_mul=1 and MUL_LAT>1: ex_hold=1; next state MUL_WAIT with cnt=MUL_LAT-2.
  - In MUL_WAIT: ex_hold=(cnt!=0). cnt decrements each cycle regardless of MEM_stall. When cnt==0, return to IDLE.
  - Net effect: the multiply resides in EX exactly MUL_LAT cycles, with MUL_LAT-1 hold cycles. MUL_LAT=1 gives no hold and the FSM never leaves IDLE.
  - mul_busy = (state==MUL_WAIT).
- Load-use:
  - lu = EX_ld & EX_we & EX_rd!=0 & D_valid & ((D_use_rs1 & D_rs1==EX_rd) | (D_use_rs2 & D_rs2==EX_rd)).
  - Effect: stall_D=1, stall_F=1 for one cycle (the bubble then removes the match).
- Mispredict:
  - mp = EX_brn & (EX_br_taken != EX_BP_taken | (EX_br_taken & EX_BP_taken & EX_br_target != EX_BP_target_pc)).
  - Effect: EX_taken=1 and redirect_valid=1. redirect_pc = EX_br_taken ? EX_br_target : EX_pc_plus4; redirect_pc is 0 when redirect_valid=0.
- Priority and gating (all outputs combinational from inputs and state):
  - MEM_stall=1: stall_D=0, EX_taken=0, redirect_valid=0. A bubble or flush must never destroy a held EX. stall_F=1.
  - ex_hold=1: stall_F=1, stall_D=0, EX_taken=0.
  - Otherwise, mp takes precedence over lu. When mp=1, stall_D=0 and stall_F=0, because the flush already discards D.
  - A branch stalled by MEM_stall is resolved in the first cycle MEM_stall drops.
- rst asserted mid-MUL_WAIT: return to IDLE immediately at the edge.

Optional Feature:
HAZARD_PERF_CNT_EN
- Defined: adds three 32-bit wrapping outputs, cnt_lu_stall, cnt_mul_hold and cnt_mispredict. Each increments on cycles where, respectively, the lu stall, ex_hold, or EX_taken is actually asserted. All three clear on rst.
- Undefined: the ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg: state enum (IDLE, MUL_WAIT), MUL_CNT_W=4, and the VPC_BITS default.
- One sub-module, mul_seq: FSM plus down-counter. Inputs EX_mul and rst; outputs ex_hold and mul_busy.
- Hazard compare and redirect mux stay in the top module.

Test Plan:
- Load x5 in EX, D add uses rs2=x5 -> stall_D=1, stall_F=1 for exactly 1 cycle. Same with EX_rd=0 -> no stall.
- MUL_LAT=3, mul enters EX -> ex_hold=1 for 2 cycles, mul_busy=1 in the second only, FSM back to IDLE. Repeat with MEM_stall during hold -> hold ends after 2 cycles, counter unaffected.
- Branch with BP_taken=0, br_taken=1, target 0x100 -> EX_taken=1, redirect_pc=0x100 for 1 cycle. BP_taken=1 and br_taken=0 with pc_plus4 0x44 -> redirect_pc=0x44.
- Mispredict coincident with load-use match, and with MEM_stall=1 for 2 cycles -> EX_taken only in cycle 3, stall_D never asserted.
- rst asserted on cycle 1 of MUL_WAIT -> all outputs 0 next cycle. With HAZARD_PERF_CNT_EN, counters read 0.
- With HAZARD_PERF_CNT_EN: 2 load-use events, 1 mul (MUL_LAT=3) and 1 mispredict -> cnt_lu_stall=2, cnt_mul_hold=2, cnt_mispredict=1.
